// File: rtl/cache_mem_responder.sv
// -----------------------------------------------------------------------------
// cache_mem_responder
//
// Memory-side responder for the cache refill / write-back interface. It accepts
// single-word and 16-byte line read/write requests from one cache and serves
// them from a single-port synchronous word SRAM (1-cycle read latency). Read
// data returns as a ret_valid / ret_last beat stream. If a write and a read are
// accepted in the same cycle, the write always runs first.
//
// Optional feature: define MEMRESP_PERF_EN to add perf_rd_cnt / perf_wr_cnt,
// which count accepted read / write requests (wrapping, cleared by reset).
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   rd_req/rd_type/rd_addr      read request (rd_type[2]=1: 4-word line)
//   rd_rdy                      read request can be accepted
//   ret_valid/ret_last/ret_data returned read beats
//   wr_req/wr_type/wr_addr      write request (wr_type[2]=1: 4-word line)
//   wr_wstrb/wr_data            byte strobes (single word only), 128-bit data
//   wr_rdy                      write request can be accepted
//   mem_en/mem_we/mem_addr      SRAM enable, byte write enables (0 = read),
//   mem_wdata/mem_rdata         word address, write data, read data
//   perf_rd_cnt/perf_wr_cnt     accepted request counters (MEMRESP_PERF_EN)
// -----------------------------------------------------------------------------
module cache_mem_responder #(
    parameter int MEM_AW = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [2:0]        rd_type,
    input  logic [31:0]       rd_addr,
    output logic              rd_rdy,
    output logic              ret_valid,
    output logic              ret_last,
    output logic [31:0]       ret_data,
    input  logic              wr_req,
    input  logic [2:0]        wr_type,
    input  logic [31:0]       wr_addr,
    input  logic [3:0]        wr_wstrb,
    input  logic [127:0]      wr_data,
    output logic              wr_rdy,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
`ifdef MEMRESP_PERF_EN
    ,
    output logic [31:0]       perf_rd_cnt,
    output logic [31:0]       perf_wr_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RD_DRAIN} state_t;

    state_t              state_q, state_d;
    logic                rd_pend_q, rd_pend_d;
    logic [1:0]          cnt_q, cnt_d;        // issue index within a burst
    logic [1:0]          beat_q, beat_d;      // returned-beat index
    logic                ret_valid_q, ret_valid_d;

    logic                wr_line_q, wr_line_d;
    logic [MEM_AW-1:0]   wr_waddr_q, wr_waddr_d;
    logic [1:0]          wr_sel_q, wr_sel_d;
    logic [3:0]          wr_strb_q, wr_strb_d;
    logic [127:0]        wr_data_q, wr_data_d;
    logic                rd_line_q, rd_line_d;
    logic [MEM_AW-1:0]   rd_waddr_q, rd_waddr_d;

    logic                rd_acc, wr_acc, rd_issue;

    // Ready depends only on state and reset, never on the requests themselves:
    // the cache gates wr_req with wr_rdy, so a request path would form a loop.
    assign rd_rdy = (state_q == S_IDLE) && !reset;
    assign wr_rdy = (state_q == S_IDLE) && !reset;
    assign rd_acc = rd_req && rd_rdy;
    assign wr_acc = wr_req && wr_rdy;

    assign ret_valid = ret_valid_q && !reset;
    assign ret_data  = mem_rdata;
    assign ret_last  = ret_valid && (beat_q == (rd_line_q ? 2'd3 : 2'd0));

    // Address bits outside the SRAM word range and the low type bits are unused.
    logic unused_bits;
    assign unused_bits = ^{rd_type[1:0], rd_addr[31:MEM_AW+2], rd_addr[1:0],
                           wr_type[1:0], wr_addr[31:MEM_AW+2], wr_addr[1:0]};

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        rd_pend_d   = rd_pend_q;
        cnt_d       = cnt_q;
        beat_d      = beat_q;
        wr_line_d   = wr_line_q;
        wr_waddr_d  = wr_waddr_q;
        wr_sel_d    = wr_sel_q;
        wr_strb_d   = wr_strb_q;
        wr_data_d   = wr_data_q;
        rd_line_d   = rd_line_q;
        rd_waddr_d  = rd_waddr_q;
        rd_issue    = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 4'h0;
        mem_addr    = '0;
        mem_wdata   = '0;

        if (ret_valid) begin
            beat_d = beat_q + 2'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (wr_acc) begin
                    wr_line_d  = wr_type[2];
                    wr_waddr_d = wr_addr[MEM_AW+1:2];
                    wr_sel_d   = wr_addr[3:2];
                    wr_strb_d  = wr_wstrb;
                    wr_data_d  = wr_data;
                end
                if (rd_acc) begin
                    rd_line_d  = rd_type[2];
                    rd_waddr_d = rd_addr[MEM_AW+1:2];
                    rd_pend_d  = 1'b1;
                end
                if (rd_acc || wr_acc) begin
                    cnt_d  = 2'd0;
                    beat_d = 2'd0;
                end
                if (wr_acc) begin
                    state_d = S_WR;
                end else if (rd_acc) begin
                    state_d = S_RD;
                end
            end
            S_WR: begin
                mem_en = 1'b1;
                if (wr_line_q) begin
                    mem_addr  = {wr_waddr_q[MEM_AW-1:2], cnt_q};
                    mem_we    = 4'hf;
                    mem_wdata = wr_data_q[{cnt_q, 5'd0} +: 32];
                end else begin
                    mem_addr  = wr_waddr_q;
                    mem_we    = wr_strb_q;
                    mem_wdata = wr_data_q[{wr_sel_q, 5'd0} +: 32];
                end
                if (!wr_line_q || cnt_q == 2'd3) begin
                    cnt_d   = 2'd0;
                    state_d = rd_pend_q ? S_RD : S_IDLE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_RD: begin
                mem_en   = 1'b1;
                rd_issue = 1'b1;
                mem_addr = rd_line_q ? {rd_waddr_q[MEM_AW-1:2], cnt_q} : rd_waddr_q;
                if (!rd_line_q || cnt_q == 2'd3) begin
                    cnt_d     = 2'd0;
                    rd_pend_d = 1'b0;
                    state_d   = S_RD_DRAIN;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_RD_DRAIN: begin
                if (ret_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A burst in flight is cut off immediately when reset is raised.
        if (reset) begin
            mem_en   = 1'b0;
            mem_we   = 4'h0;
            rd_issue = 1'b0;
        end

        // Tracks read issue explicitly: a zero-strobe write also has mem_we==0.
        ret_valid_d = rd_issue;
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rd_pend_q   <= 1'b0;
            cnt_q       <= 2'd0;
            beat_q      <= 2'd0;
            ret_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_pend_q   <= rd_pend_d;
            cnt_q       <= cnt_d;
            beat_q      <= beat_d;
            ret_valid_q <= ret_valid_d;
        end
    end

    // NOTE: the request datapath registers are deliberately not reset; they are
    // always loaded on acceptance before being used, so a reset would only add
    // fan-out on the reset net.
    always_ff @(posedge clk) begin
        wr_line_q  <= wr_line_d;
        wr_waddr_q <= wr_waddr_d;
        wr_sel_q   <= wr_sel_d;
        wr_strb_q  <= wr_strb_d;
        wr_data_q  <= wr_data_d;
        rd_line_q  <= rd_line_d;
        rd_waddr_q <= rd_waddr_d;
    end

`ifdef MEMRESP_PERF_EN
    logic [31:0] perf_rd_cnt_q, perf_rd_cnt_d;
    logic [31:0] perf_wr_cnt_q, perf_wr_cnt_d;

    always_comb begin
        perf_rd_cnt_d = perf_rd_cnt_q + {31'd0, rd_acc};
        perf_wr_cnt_d = perf_wr_cnt_q + {31'd0, wr_acc};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_rd_cnt_q <= 32'd0;
            perf_wr_cnt_q <= 32'd0;
        end else begin
            perf_rd_cnt_q <= perf_rd_cnt_d;
            perf_wr_cnt_q <= perf_wr_cnt_d;
        end
    end

    assign perf_rd_cnt = perf_rd_cnt_q;
    assign perf_wr_cnt = perf_wr_cnt_q;
`endif

endmodule

// File: tb/tb_cache_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_cache_mem_responder
//
// Bench for cache_mem_responder: directed cases followed by random request
// mixes. A word-array reference model predicts returned beats (pushed into a
// queue when a request is issued); an independent monitor pops and compares
// whenever ret_valid is seen. Busy time and SRAM enable cycles are checked per
// transaction. Define MEMRESP_PERF_EN to also check the request counters.
// -----------------------------------------------------------------------------
module tb_cache_mem_responder;

    localparam int MEM_AW = 14;
    localparam int DEPTH  = 1 << MEM_AW;

    logic              clk = 1'b0;
    logic              reset;
    logic              rd_req;
    logic [2:0]        rd_type;
    logic [31:0]       rd_addr;
    logic              rd_rdy;
    logic              ret_valid;
    logic              ret_last;
    logic [31:0]       ret_data;
    logic              wr_req;
    logic [2:0]        wr_type;
    logic [31:0]       wr_addr;
    logic [3:0]        wr_wstrb;
    logic [127:0]      wr_data;
    logic              wr_rdy;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
`ifdef MEMRESP_PERF_EN
    logic [31:0]       perf_rd_cnt;
    logic [31:0]       perf_wr_cnt;
`endif

    always #5 clk = ~clk;

    cache_mem_responder #(.MEM_AW(MEM_AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_req    (rd_req),
        .rd_type   (rd_type),
        .rd_addr   (rd_addr),
        .rd_rdy    (rd_rdy),
        .ret_valid (ret_valid),
        .ret_last  (ret_last),
        .ret_data  (ret_data),
        .wr_req    (wr_req),
        .wr_type   (wr_type),
        .wr_addr   (wr_addr),
        .wr_wstrb  (wr_wstrb),
        .wr_data   (wr_data),
        .wr_rdy    (wr_rdy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef MEMRESP_PERF_EN
        ,
        .perf_rd_cnt (perf_rd_cnt),
        .perf_wr_cnt (perf_wr_cnt)
`endif
    );

    // ---------------- SRAM attached to the DUT ----------------
    logic [31:0] sram [DEPTH];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we == 4'h0) begin
                mem_rdata <= sram[mem_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic [31:0] ref_mem [DEPTH];
    beat_t       exp_q [$];
    beat_t       mon_b;
    bit          mon_en = 1'b1;
    int          checks = 0;
    int          errors = 0;
    int          exp_rd_cnt = 0;
    int          exp_wr_cnt = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int word_index(logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic model_write(bit ln, logic [31:0] a, logic [3:0] st, logic [127:0] d);
        int idx;
        int base;
        int sel;
        logic [31:0] w;
        idx = word_index(a);
        if (ln) begin
            base = idx - (idx % 4);
            for (int k = 0; k < 4; k++) ref_mem[base + k] = d[32*k +: 32];
        end else begin
            sel = int'((a >> 2) % 4);
            w = d[32*sel +: 32];
            for (int b = 0; b < 4; b++) begin
                if (st[b]) ref_mem[idx][8*b +: 8] = w[8*b +: 8];
            end
        end
    endtask

    task automatic model_read(bit ln, logic [31:0] a);
        int idx;
        int base;
        idx = word_index(a);
        if (ln) begin
            base = idx - (idx % 4);
            for (int k = 0; k < 4; k++) exp_q.push_back('{data: ref_mem[base + k], last: (k == 3)});
        end else begin
            exp_q.push_back('{data: ref_mem[idx], last: 1'b1});
        end
    endtask

    // Monitor: independent of the stimulus, compares every presented beat.
    always @(negedge clk) begin
        if (mon_en && ret_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {63'd0, ret_valid}, 64'd0);
            end else begin
                mon_b = exp_q.pop_front();
                check("ret_data", {32'd0, ret_data}, {32'd0, mon_b.data});
                check("ret_last", {63'd0, ret_last}, {63'd0, mon_b.last});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_txn(bit do_rd, bit rd_ln, logic [31:0] ra,
                          bit do_wr, bit wr_ln, logic [31:0] wa,
                          logic [3:0] st, logic [127:0] wd);
        int guard;
        int busy;
        int ens;
        int nw;
        int nr;
        guard = 0;
        while (!(rd_rdy === 1'b1 && wr_rdy === 1'b1) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("idle_rdy", {62'd0, rd_rdy, wr_rdy}, 64'd3);
        rd_req   = do_rd;
        rd_type  = rd_ln ? 3'b100 : 3'b010;
        rd_addr  = ra;
        wr_req   = do_wr;
        wr_type  = wr_ln ? 3'b100 : 3'b010;
        wr_addr  = wa;
        wr_wstrb = st;
        wr_data  = wd;
        nw = do_wr ? (wr_ln ? 4 : 1) : 0;
        nr = do_rd ? (rd_ln ? 4 : 1) : 0;
        if (do_wr) begin
            model_write(wr_ln, wa, st, wd);
            exp_wr_cnt++;
        end
        if (do_rd) begin
            model_read(rd_ln, ra);
            exp_rd_cnt++;
        end
        @(negedge clk);
        rd_req = 1'b0;
        wr_req = 1'b0;
        busy = 0;
        ens  = 0;
        while (rd_rdy !== 1'b1 && busy < 40) begin
            busy++;
            if (mem_en === 1'b1) ens++;
            @(negedge clk);
        end
        if (mem_en === 1'b1) ens++;
        check("busy_cycles", 64'(busy), 64'(nw + nr + (do_rd ? 1 : 0)));
        check("mem_en_cycles", 64'(ens), 64'(nw + nr));
        check("beats_pending", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        return ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 255));
    endfunction

    initial begin
        int ret_seen;
        int en_seen;
        int sel;

        reset    = 1'b1;
        rd_req   = 1'b1;
        rd_type  = 3'b100;
        rd_addr  = 32'h0000_0100;
        wr_req   = 1'b0;
        wr_type  = 3'b000;
        wr_addr  = 32'h0;
        wr_wstrb = 4'h0;
        wr_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sram[i]    = $urandom;
            ref_mem[i] = sram[i];
        end
        for (int i = 0; i < 4; i++) begin
            sram[32'h40 + i]    = 32'hA0 + 32'(i);
            ref_mem[32'h40 + i] = 32'hA0 + 32'(i);
        end

        // Reset state, with a request held high that must not be accepted.
        repeat (3) @(negedge clk);
        check("reset_outputs", {58'd0, rd_rdy, wr_rdy, ret_valid, ret_last, mem_en, |mem_we}, 64'd0);
        rd_req = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        check("rdy_after_reset", {62'd0, rd_rdy, wr_rdy}, 64'd3);
        check("no_access_after_reset", {63'd0, mem_en}, 64'd0);

        // Directed: line read, single read, partial single write.
        do_txn(1, 1, 32'h0000_010C, 0, 0, 32'h0, 4'h0, '0);
        do_txn(1, 0, 32'h0000_0108, 0, 0, 32'h0, 4'h0, '0);
        sram[32'h41]    = 32'h1122_3344;
        ref_mem[32'h41] = 32'h1122_3344;
        do_txn(0, 0, 32'h0, 1, 0, 32'h0000_0104, 4'b0011,
               {32'h5555_5555, 32'h6666_6666, 32'hDEAD_BEEF, 32'h7777_7777});
        check("partial_write_word", {32'd0, sram[32'h41]}, {32'd0, 32'h1122_BEEF});
        // Same-cycle line write and line read of the same line.
        do_txn(1, 1, 32'h0000_0200, 1, 1, 32'h0000_0200, 4'h0,
               {32'd4, 32'd3, 32'd2, 32'd1});

        // Reset in the middle of a line read, on the cycle beat 2 is presented.
        mon_en  = 1'b0;
        rd_req  = 1'b1;
        rd_type = 3'b100;
        rd_addr = 32'h0000_0100;
        @(negedge clk);
        rd_req = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_outputs", {61'd0, rd_rdy, ret_valid, mem_en}, 64'd0);
`ifdef MEMRESP_PERF_EN
        check("perf_rd_after_reset", {32'd0, perf_rd_cnt}, 64'd0);
        check("perf_wr_after_reset", {32'd0, perf_wr_cnt}, 64'd0);
`endif
        exp_rd_cnt = 0;
        exp_wr_cnt = 0;
        reset = 1'b0;
        ret_seen = 0;
        en_seen  = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) check("rdy_after_mid_reset", {63'd0, rd_rdy}, 64'd1);
            if (ret_valid === 1'b1) ret_seen++;
            if (mem_en === 1'b1) en_seen++;
        end
        check("no_beats_after_reset", 64'(ret_seen), 64'd0);
        check("no_access_after_mid_reset", 64'(en_seen), 64'd0);
        mon_en = 1'b1;
        do_txn(1, 0, 32'h0000_0108, 0, 0, 32'h0, 4'h0, '0);

        // Random mixes: read only, write only, or both in the same cycle.
        for (int i = 0; i < 80; i++) begin
            sel = int'($urandom_range(0, 2));
            do_txn(sel != 1, 1'($urandom), rand_addr(),
                   sel != 0, 1'($urandom), rand_addr(), 4'($urandom),
                   {$urandom, $urandom, $urandom, $urandom});
        end

`ifdef MEMRESP_PERF_EN
        check("perf_rd_cnt", {32'd0, perf_rd_cnt}, 64'(exp_rd_cnt));
        check("perf_wr_cnt", {32'd0, perf_wr_cnt}, 64'(exp_wr_cnt));
`endif

        repeat (3) @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cache_mem_responder.md
# cache_mem_responder

Memory-side responder for the cache refill/write-back interface. It accepts the cache's `rd_req`/`wr_req` transactions, both single-word (uncached) and 16-byte line, and serves them from a single-port synchronous word SRAM. Read data goes back to the cache as a `ret_valid`/`ret_last` beat stream. It sits between the I/D cache instances and on-chip memory; each cache gets its own instance.

## Interface
Parameters:
- `MEM_AW`, default 14: SRAM word-address width; byte address bits `[MEM_AW+1:2]` are used and upper bits are ignored.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `rd_req` in 1: read request.
- `rd_type` in 3: `rd_type[2]`=1 means 4-word line; otherwise single word.
- `rd_addr` in 32: read byte address.
- `rd_rdy` out 1: read request can be accepted.
- `ret_valid` out 1: `ret_data` is valid this cycle.
- `ret_last` out 1: final beat of the read.
- `ret_data` out 32: returned word.
- `wr_req` in 1: write request.
- `wr_type` in 3: `wr_type[2]`=1 means 4-word line; otherwise single word.
- `wr_addr` in 32: write byte address.
- `wr_wstrb` in 4: byte strobes, single-word writes only.
- `wr_data` in 128: write data; word k is bits `[32k+31:32k]`.
- `wr_rdy` out 1: write request can be accepted.
- `mem_en` out 1: SRAM access enable.
- `mem_we` out 4: SRAM byte write enables; 0 means read.
- `mem_addr` out MEM_AW: SRAM word address.
- `mem_wdata` out 32: SRAM write data.
- `mem_rdata` in 32: SRAM read data, valid 1 cycle after a read access.

## Operation
- States: IDLE, WR, RD, RD_DRAIN.
- `rd_rdy` = `wr_rdy` = (state==IDLE) && !reset.
  - Neither output may depend on `rd_req` or `wr_req`, because the cache gates `wr_req` with `wr_rdy`.
- Acceptance:
  - A request is accepted on a cycle where req && rdy.
  - Both requests may be accepted in the same IDLE cycle. Both are latched (address, type, strobes, 128-bit data).
  - The write always executes before the read.
- IDLE transitions:
  - Write accepted → WR.
  - Only a read accepted → RD.
  - Nothing accepted → stay.
- WR:
  - Line write: issues 4 SRAM writes, word addresses `{addr[MEM_AW+1:4],k}` for k=0..3, data = `wr_data` word k, `mem_we`=4'hf.
  - Single write: one SRAM write to `addr[MEM_AW+1:2]`, data = `wr_data` word `wr_addr[3:2]`, `mem_we`=`wr_wstrb`.
  - After the last write: go to RD if a read is pending, else IDLE.
- RD:
  - Issues reads in ascending word order: k=0..3 for a line (address `rd_addr[3:0]` ignored), or one read at `rd_addr[MEM_AW+1:2]`.
  - After the last issue → RD_DRAIN.
- RD_DRAIN: waits for the final beat, then → IDLE.
- Return path:
  - `ret_valid` is a registered copy of "read issued last cycle".
  - `ret_data` = `mem_rdata`.
  - `ret_last` = `ret_valid` && (beat index == 3 for a line, 0 for a single word).
- A 2-bit beat counter clears on acceptance; it wraps only via reset or new acceptance.
- The responder performs no coherence checks and no merging; a line is always read from SRAM after any same-cycle write has completed.

## Timing
- Reset:
  - Outputs: `ret_valid`, `ret_last`, `mem_en`, `mem_we` = 0; `ret_data` follows `mem_rdata` but is qualified by `ret_valid`=0.
  - `rd_rdy`/`wr_rdy` = 0 during reset and 1 the first cycle after.
  - State goes to IDLE, all pending flags and counters clear.
- Reset mid-burst: the burst is dropped with no further `ret_valid` or `mem_en` from the next cycle on.
- Line read accepted at T:
  - SRAM reads at T+1..T+4.
  - `ret_valid` at T+2..T+5, with `ret_last` at T+5.
  - `rd_rdy` high again at T+6.
- Single read accepted at T: read at T+1, `ret_valid`+`ret_last` at T+2, IDLE at T+3.
- Line write accepted at T: SRAM writes at T+1..T+4, `wr_rdy` high at T+5.
- Single write accepted at T: write at T+1, `wr_rdy` high at T+2.
- Simultaneous line write + line read accepted at T:
  - Writes at T+1..T+4, reads at T+5..T+8.
  - `ret_last` at T+9, IDLE at T+10.
- The cache must hold `rd_req`/`wr_req` low after acceptance until it wants a new transaction; the responder ignores requests outside IDLE.

## Configuration
- `MEMRESP_PERF_EN` defined:
  - Adds output ports `perf_rd_cnt` (32) and `perf_wr_cnt` (32).
  - These count accepted read and write requests, wrap at 2^32, and clear on reset.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Preload SRAM words 0x40..0x43 with 0xA0..0xA3. Line read at `rd_addr`=0x0000_010C → `ret_data` A0,A1,A2,A3 on 4 consecutive cycles, `ret_last` only on A3, `rd_rdy` low for exactly 5 cycles.
- Single read at 0x0000_0108 (`rd_type`=010) → one beat = word 0x42 with `ret_valid`&&`ret_last`, back in IDLE 2 cycles later.
- Single write at 0x0000_0104, `wr_wstrb`=4'b0011, `wr_data` word1=0xDEADBEEF over old 0x11223344 → SRAM word 0x41 becomes 0x1122BEEF, and only one `mem_en` cycle occurs.
- Same-cycle line write to 0x200 (data 1,2,3,4) + line read of 0x200 → returned beats 1,2,3,4; `ret_last` at T+9.
- Assert reset during beat 2 of a line read → no further `ret_valid`; `rd_rdy`=1 the cycle after reset deasserts; a new single read then completes normally.
- With `MEMRESP_PERF_EN`: 3 reads and 2 writes → `perf_rd_cnt`=3, `perf_wr_cnt`=2; after reset both are 0.
